// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths, state type and helpers for the PE shift accumulator
package pe_pkg;

    localparam int PE_SUM_W = 10;
    localparam int PE_ACC_W = 24;
    localparam int PE_SH_W  = 4;
    localparam int PE_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } acc_state_t;

    // Beat counter sticks at all-ones instead of wrapping.
    function automatic logic [PE_CNT_W-1:0] sat_inc(input logic [PE_CNT_W-1:0] c);
        return (c == {PE_CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/pe_shift_accumulator_if.sv
// rtl/pe_shift_accumulator_if.sv - beat input, result output and flag signals of the shift accumulator
interface pe_shift_accumulator_if
    import pe_pkg::*;
#(
    parameter int IN_W  = PE_SUM_W,
    parameter int SH_W  = PE_SH_W,
    parameter int ACC_W = PE_ACC_W
);

    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     pe_sum;
    logic [SH_W-1:0]     shift_amt;
    logic                first;
    logic                last;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_W-1:0]    acc_out;
    logic [PE_CNT_W-1:0] beat_cnt;
    logic                ovf;
    logic                err;
    logic                clr_err;

    modport master (
        output in_valid, pe_sum, shift_amt, first, last, out_ready, clr_err,
        input  in_ready, out_valid, acc_out, beat_cnt, ovf, err
    );

    modport slave (
        input  in_valid, pe_sum, shift_amt, first, last, out_ready, clr_err,
        output in_ready, out_valid, acc_out, beat_cnt, ovf, err
    );

endinterface

// File: rtl/pe_shift_term.sv
// rtl/pe_shift_term.sv - sign-extend a PE partial sum and shift it to its slice significance
module pe_shift_term
    import pe_pkg::*;
#(
    parameter int IN_W  = PE_SUM_W,
    parameter int SH_W  = PE_SH_W,
    parameter int ACC_W = PE_ACC_W
) (
    input  logic [IN_W-1:0]  pe_sum,
    input  logic [SH_W-1:0]  shift_amt,
    output logic [ACC_W-1:0] term,
    output logic             illegal
);

    localparam int MAX_SH = ACC_W - IN_W;

    logic [ACC_W-1:0] ext;

    assign ext = {{(ACC_W-IN_W){pe_sum[IN_W-1]}}, pe_sum};

    // Shifts that would push sign bits past the accumulator are rejected and contribute nothing.
    assign illegal = int'(shift_amt) > MAX_SH;
    assign term    = illegal ? '0 : (ext << shift_amt);

endmodule

// File: rtl/pe_shift_accumulator.sv
// rtl/pe_shift_accumulator.sv - fuses shifted PE partial sums into one full-precision group result
module pe_shift_accumulator
    import pe_pkg::*;
#(
    parameter int IN_W  = PE_SUM_W,
    parameter int SH_W  = PE_SH_W,
    parameter int ACC_W = PE_ACC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_shift_accumulator_if.slave bus
);

    acc_state_t          state;
    logic [ACC_W-1:0]    acc;
    logic [PE_CNT_W-1:0] cnt;

    logic                out_valid;
    logic [ACC_W-1:0]    acc_out;
    logic [PE_CNT_W-1:0] beat_cnt;
    logic                ovf;
    logic                err;

    logic [ACC_W-1:0]    term;
    logic                illegal;
    logic                accept;
    logic                take;
    logic                restart;
    logic [ACC_W-1:0]    base;
    logic [ACC_W-1:0]    sum;
    logic                add_ovf;
    logic [PE_CNT_W-1:0] next_cnt;
    logic                proto_err;

    pe_shift_term #(
        .IN_W  (IN_W),
        .SH_W  (SH_W),
        .ACC_W (ACC_W)
    ) u_term (
        .pe_sum    (bus.pe_sum),
        .shift_amt (bus.shift_amt),
        .term      (term),
        .illegal   (illegal)
    );

    // The output register is the only buffer: a pending result stalls input unless it drains this cycle.
    assign bus.in_ready = !rst && (!out_valid || bus.out_ready);

    assign accept = bus.in_valid && bus.in_ready;
    assign take   = out_valid && bus.out_ready;

    // A beat arriving with no open group is handled exactly like a group opener.
    assign restart  = bus.first || (state == IDLE);
    assign base     = restart ? '0 : acc;
    assign sum      = base + term;
    assign add_ovf  = (base[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    assign next_cnt = restart ? PE_CNT_W'(1) : sat_inc(cnt);

    assign proto_err = illegal
                    || ((state == IDLE) && !bus.first)
                    || ((state == RUN)  &&  bus.first);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            beat_cnt  <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                if (bus.last) begin
                    state <= IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                end else begin
                    state <= RUN;
                    acc   <= sum;
                    cnt   <= next_cnt;
                end
            end

            // A new result landing in the same cycle as a take keeps the register full.
            if (accept && bus.last) begin
                out_valid <= 1'b1;
                acc_out   <= sum;
                beat_cnt  <= next_cnt;
            end else if (take) begin
                out_valid <= 1'b0;
            end

            if (accept && add_ovf) begin
                ovf <= 1'b1;
            end else if (bus.clr_err) begin
                ovf <= 1'b0;
            end

            if (accept && proto_err) begin
                err <= 1'b1;
            end else if (bus.clr_err) begin
                err <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.acc_out   = acc_out;
    assign bus.beat_cnt  = beat_cnt;
    assign bus.ovf       = ovf;
    assign bus.err       = err;

endmodule

// File: tb/tb_pe_shift_accumulator.sv
// tb/tb_pe_shift_accumulator.sv - scoreboard bench for the PE shift accumulator
module tb_pe_shift_accumulator;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_shift_accumulator_if dif ();

    pe_shift_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
        logic        err;
    } exp_t;

    exp_t sb[$];

    // Reference state: group open flag, running sum as a plain integer, count and sticky flags.
    bit     m_open = 0;
    longint m_acc  = 0;
    int     m_cnt  = 0;
    bit     m_ovf  = 0;
    bit     m_err  = 0;
    bit     rand_rdy = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap24(input longint v);
        logic signed [23:0] w;
        w = v[23:0];
        return longint'(w);
    endfunction

    task automatic model_beat(input int pe, input int sh, input bit f, input bit l);
        longint t;
        longint raw;
        exp_t   e;
        t = (sh > 14) ? 64'sd0 : longint'(pe) * (longint'(1) << sh);
        if (sh > 14) m_err = 1;
        if (!m_open || f) begin
            if (m_open == f) m_err = 1;
            m_acc = t;
            m_cnt = 1;
        end else begin
            raw = m_acc + t;
            if (raw > 8388607 || raw < -8388608) m_ovf = 1;
            m_acc = wrap24(raw);
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        m_open = 1;
        if (l) begin
            e.acc = m_acc[23:0];
            e.cnt = m_cnt[7:0];
            e.ovf = m_ovf;
            e.err = m_err;
            sb.push_back(e);
            m_open = 0;
            m_acc  = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic beat(input int pe, input int sh, input bit f, input bit l);
        bit got;
        got = 0;
        dif.in_valid  = 1'b1;
        dif.pe_sum    = pe[9:0];
        dif.shift_amt = sh[3:0];
        dif.first     = f;
        dif.last      = l;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dif.in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            check("beat_accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
            model_beat(pe, sh, f, l);
        end
        #1;
        dif.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic clear_flags();
        dif.clr_err = 1'b1;
        @(posedge clk);
        m_err = 0;
        m_ovf = 0;
        #1;
        dif.clr_err = 1'b0;
        check("clr_err_err", dif.err, 0);
        check("clr_err_ovf", dif.ovf, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",  dif.in_ready, 0);
        check("rst_out_valid", dif.out_valid, 0);
        check("rst_acc_out",   dif.acc_out, 0);
        check("rst_beat_cnt",  dif.beat_cnt, 0);
        check("rst_ovf",       dif.ovf, 0);
        check("rst_err",       dif.err, 0);
    endtask

    // Monitor: compares each taken result and checks output stability while stalled.
    initial begin
        bit          hold = 0;
        logic [23:0] h_acc;
        logic [7:0]  h_cnt;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst && dif.out_valid) begin
                if (hold) begin
                    check("hold_acc_out",  dif.acc_out, h_acc);
                    check("hold_beat_cnt", dif.beat_cnt, h_cnt);
                end
                if (dif.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("acc_out",  dif.acc_out, e.acc);
                        check("beat_cnt", dif.beat_cnt, e.cnt);
                        check("ovf",      dif.ovf, e.ovf);
                        check("err",      dif.err, e.err);
                    end
                end
                hold  = !dif.out_ready;
                h_acc = dif.acc_out;
                h_cnt = dif.beat_cnt;
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) dif.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int len;
        int pe;
        int sh;
        bit f;

        dif.in_valid  = 1'b0;
        dif.pe_sum    = '0;
        dif.shift_amt = '0;
        dif.first     = 1'b0;
        dif.last      = 1'b0;
        dif.out_ready = 1'b1;
        dif.clr_err   = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", dif.in_ready, 1);
        @(posedge clk);
        #1;

        // Three-beat group with mixed signs and shifts.
        beat(5, 0, 1, 0);
        beat(-3, 3, 0, 0);
        beat(1, 6, 0, 1);
        drain();

        // Most negative single term, then a group that wraps past it.
        beat(-512, 14, 1, 1);
        beat(-512, 14, 1, 0);
        beat(-1, 0, 0, 1);
        drain();
        clear_flags();

        // Stall with a pending result, then take it while a new last beat arrives.
        dif.out_ready = 1'b0;
        beat(10, 0, 1, 1);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", dif.in_ready, 0);
            check("stall_acc_out", dif.acc_out, 10);
        end
        @(posedge clk);
        #1;
        dif.out_ready = 1'b1;
        beat(3, 1, 1, 1);
        @(negedge clk);
        check("back_to_back_valid", dif.out_valid, 1);
        check("back_to_back_acc", dif.acc_out, 6);
        @(posedge clk);
        #1;
        drain();

        // Illegal shift contributes zero and raises err.
        beat(7, 15, 1, 1);
        drain();
        clear_flags();

        // Missing first from idle.
        beat(4, 1, 0, 1);
        drain();
        clear_flags();

        // Beat count saturation over a long group.
        beat(1, 0, 1, 0);
        for (int i = 0; i < 298; i++) beat(1, 0, 0, 0);
        beat(1, 0, 0, 1);
        drain();

        // Reset in the middle of an open group.
        beat(9, 2, 1, 0);
        beat(-7, 4, 0, 0);
        rst = 1'b1;
        m_open = 0;
        m_acc  = 0;
        m_ovf  = 0;
        m_err  = 0;
        sb.delete();
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst2_in_ready", dif.in_ready, 1);
        beat(2, 2, 1, 1);
        drain();

        // Randomized groups with a randomly stalling consumer.
        for (int g = 0; g < 60; g++) begin
            if (g % 10 == 0) begin
                rand_rdy = 0;
                @(posedge clk);
                #1;
                dif.out_ready = 1'b1;
                drain();
                clear_flags();
                rand_rdy = 1;
            end
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                pe = int'($urandom_range(0, 1023)) - 512;
                sh = ($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 14));
                f  = (b == 0);
                if ($urandom_range(0, 9) == 0) f = !f;
                beat(pe, sh, f, b == len - 1);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        rand_rdy = 0;
        @(posedge clk);
        #1;
        dif.out_ready = 1'b1;
        drain();
        check("final_no_pending", dif.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
